// File: rtl/ddr_rw_arbiter.sv
// ddr_rw_arbiter: grants one DDR burst at a time to the write or read AXI controller.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: write priority).
module ddr_rw_arbiter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic              clk_100M,
  input  logic              rstn,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              wr_done,
  output logic              rd_done,
  output logic              wr_err,
  output logic              rd_err,
  output logic              wc_req,
  output logic              rc_req,
  output logic [ADDR_W-1:0] wc_addr,
  output logic [LEN_W-1:0]  wc_len,
  output logic [ADDR_W-1:0] rc_addr,
  output logic [LEN_W-1:0]  rc_len,
  input  logic              wc_busy,
  input  logic              rc_busy,
  output logic              arb_busy
);

  localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    WR_START = 5'b00010,
    WR_WAIT  = 5'b00100,
    RD_START = 5'b01000,
    RD_WAIT  = 5'b10000
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             any_req;
  logic             pick_wr;
  logic             tmo_hit;
  logic             grant;

  always_comb any_req = wr_req | rd_req;
  always_comb grant   = (state == IDLE) & init_done & any_req;
  // Abort on the TMO_CYC-th start cycle so the start request is seen exactly TMO_CYC cycles.
  always_comb tmo_hit = (tmo_cnt == CNT_W'(TMO_CYC - 1));

`ifdef ARB_ROUND_ROBIN_EN
  logic last_wr;

  always_comb pick_wr = wr_req & (~rd_req | ~last_wr);

  always_ff @(posedge clk_100M or negedge rstn) begin
    if (!rstn)      last_wr <= 1'b0;
    else if (grant) last_wr <= pick_wr;
  end
`else
  always_comb pick_wr = wr_req;
`endif

  always_ff @(posedge clk_100M or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      wc_req   <= 1'b0;
      rc_req   <= 1'b0;
      wc_addr  <= '0;
      wc_len   <= '0;
      rc_addr  <= '0;
      rc_len   <= '0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
      arb_busy <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      wr_err  <= 1'b0;
      rd_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            tmo_cnt  <= '0;
            arb_busy <= 1'b1;
            if (pick_wr) begin
              state   <= WR_START;
              wc_req  <= 1'b1;
              wc_addr <= wr_addr;
              wc_len  <= wr_len;
            end else begin
              state   <= RD_START;
              rc_req  <= 1'b1;
              rc_addr <= rd_addr;
              rc_len  <= rd_len;
            end
          end
        end
        WR_START: begin
          if (wc_busy) begin
            wc_req <= 1'b0;
            state  <= WR_WAIT;
          end else if (tmo_hit) begin
            wc_req   <= 1'b0;
            wr_done  <= 1'b1;
            wr_err   <= 1'b1;
            arb_busy <= 1'b0;
            state    <= IDLE;
          end else if (tmo_cnt != CNT_W'(TMO_CYC)) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        WR_WAIT: begin
          if (!wc_busy) begin
            wr_done  <= 1'b1;
            arb_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_START: begin
          if (rc_busy) begin
            rc_req <= 1'b0;
            state  <= RD_WAIT;
          end else if (tmo_hit) begin
            rc_req   <= 1'b0;
            rd_done  <= 1'b1;
            rd_err   <= 1'b1;
            arb_busy <= 1'b0;
            state    <= IDLE;
          end else if (tmo_cnt != CNT_W'(TMO_CYC)) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        RD_WAIT: begin
          if (!rc_busy) begin
            rd_done  <= 1'b1;
            arb_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          wc_req   <= 1'b0;
          rc_req   <= 1'b0;
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// tb_ddr_rw_arbiter: directed vectors for ddr_rw_arbiter with hand-computed expectations.
// Build with ARB_ROUND_ROBIN_EN defined to check the alternating grant order.
module tb_ddr_rw_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned LW = 4;

  logic          clk_100M = 1'b0;
  logic          rstn = 1'b0;
  logic          init_done = 1'b0;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [LW-1:0] wr_len = '0;
  logic [LW-1:0] rd_len = '0;
  logic          wr_done, rd_done, wr_err, rd_err;
  logic          wc_req, rc_req;
  logic [AW-1:0] wc_addr, rc_addr;
  logic [LW-1:0] wc_len, rc_len;
  logic          wc_busy, rc_busy;
  logic          arb_busy;

  logic          ctl_auto = 1'b0;
  logic          man_wc = 1'b0;
  logic          man_rc = 1'b0;
  logic          auto_wc = 1'b0;
  logic          auto_rc = 1'b0;
  int unsigned   auto_wcnt = 0;
  int unsigned   auto_rcnt = 0;

  int            n_vec = 0;
  int            n_err = 0;

  assign wc_busy = ctl_auto ? auto_wc : man_wc;
  assign rc_busy = ctl_auto ? auto_rc : man_rc;

  always #5 clk_100M = ~clk_100M;

  ddr_rw_arbiter #(.ADDR_W(AW), .LEN_W(LW), .TMO_CYC(255)) dut (
    .clk_100M (clk_100M),
    .rstn     (rstn),
    .init_done(init_done),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .wr_len   (wr_len),
    .rd_len   (rd_len),
    .wr_done  (wr_done),
    .rd_done  (rd_done),
    .wr_err   (wr_err),
    .rd_err   (rd_err),
    .wc_req   (wc_req),
    .rc_req   (rc_req),
    .wc_addr  (wc_addr),
    .wc_len   (wc_len),
    .rc_addr  (rc_addr),
    .rc_len   (rc_len),
    .wc_busy  (wc_busy),
    .rc_busy  (rc_busy),
    .arb_busy (arb_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk_100M);
  endtask

  // Controller stand-in: raises busy one cycle after seeing its request, holds it 3 cycles.
  always @(negedge clk_100M) begin
    if (auto_wc) begin
      if (auto_wcnt == 0) auto_wc = 1'b0;
      else auto_wcnt--;
    end else if (ctl_auto && wc_req) begin
      auto_wc = 1'b1;
      auto_wcnt = 2;
    end
    if (auto_rc) begin
      if (auto_rcnt == 0) auto_rc = 1'b0;
      else auto_rcnt--;
    end else if (ctl_auto && rc_req) begin
      auto_rc = 1'b1;
      auto_rcnt = 2;
    end
  end

  always @(posedge clk_100M)
    assert (!(wc_req && rc_req)) else $error("FAIL mutex: wc_req and rc_req both high");

  always @(negedge clk_100M)
    if (wc_req && rc_req) chk("mutex", 32'(wc_req & rc_req), 32'd0);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    int unsigned n;
    logic        seen;
    logic [3:0]  exp_seq;

`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = 4'b0101;
`else
    exp_seq = 4'b1111;
`endif

    // Reset state
    repeat (3) tick;
    chk("rst_wc_req",   32'(wc_req),   32'd0);
    chk("rst_rc_req",   32'(rc_req),   32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);
    chk("rst_wc_addr",  32'(wc_addr),  32'd0);
    chk("rst_done",     32'({wr_done, rd_done, wr_err, rd_err}), 32'd0);
    rstn = 1'b1;
    init_done = 1'b1;
    repeat (2) tick;

    // Single write burst, busy 2 cycles after request, held 10 cycles
    wr_addr = 28'h0000100;
    wr_len  = 4'd7;
    wr_req  = 1'b1;
    tick;
    chk("wr_grant",    32'(wc_req),   32'd1);
    chk("wr_addr",     32'(wc_addr),  32'h100);
    chk("wr_len",      32'(wc_len),   32'd7);
    chk("wr_busyflag", 32'(arb_busy), 32'd1);
    chk("wr_no_rc",    32'(rc_req),   32'd0);
    tick;
    chk("wr_req_cyc2", 32'(wc_req), 32'd1);
    man_wc = 1'b1;
    tick;
    chk("wr_req_drop", 32'(wc_req),   32'd0);
    chk("wr_wait",     32'(arb_busy), 32'd1);
    seen = 1'b0;
    repeat (9) begin
      tick;
      if (wr_done) seen = 1'b1;
    end
    chk("wr_early_done", 32'(seen), 32'd0);
    man_wc = 1'b0;
    tick;
    chk("wr_done",      32'(wr_done),  32'd1);
    chk("wr_err_clean", 32'(wr_err),   32'd0);
    chk("wr_idle",      32'(arb_busy), 32'd0);
    chk("rc_addr_hold", 32'(rc_addr),  32'd0);
    wr_req = 1'b0;
    tick;
    chk("wr_done_1cyc", 32'(wr_done), 32'd1 - 32'd1);
    chk("wr_no_regrnt", 32'(wc_req),  32'd0);

    // init_done gating, then init_done drop and request drop mid-burst
    init_done = 1'b0;
    wr_addr = 28'h0000200;
    wr_len  = 4'd2;
    wr_req  = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick;
      if (wc_req || arb_busy) seen = 1'b1;
    end
    chk("init_block", 32'(seen), 32'd0);
    init_done = 1'b1;
    tick;
    chk("init_grant", 32'(wc_req),  32'd1);
    chk("init_addr",  32'(wc_addr), 32'h200);
    chk("init_len",   32'(wc_len),  32'd2);
    man_wc = 1'b1;
    tick;
    chk("init_wait", 32'(wc_req), 32'd0);
    init_done = 1'b0;
    wr_req = 1'b0;
    man_wc = 1'b0;
    tick;
    chk("midburst_done", 32'(wr_done), 32'd1);
    chk("midburst_err",  32'(wr_err),  32'd0);
    init_done = 1'b1;
    tick;
    chk("midburst_idle", 32'(arb_busy), 32'd0);

    // Read timeout: controller never goes busy
    rd_addr = 28'h0ABCDEF;
    rd_len  = 4'd3;
    rd_req  = 1'b1;
    tick;
    chk("rd_tmo_addr", 32'(rc_addr), 32'h0ABCDEF);
    chk("rd_tmo_len",  32'(rc_len),  32'd3);
    n = 0;
    seen = 1'b0;
    while (rc_req && n < 300) begin
      if (rd_done) seen = 1'b1;
      n++;
      tick;
    end
    chk("rd_tmo_cycles",  n,                 32'd255);
    chk("rd_tmo_early",   32'(seen),         32'd0);
    chk("rd_tmo_done",    32'(rd_done),      32'd1);
    chk("rd_tmo_err",     32'(rd_err),       32'd1);
    chk("rd_tmo_idle",    32'(arb_busy),     32'd0);
    chk("wc_addr_hold",   32'(wc_addr),      32'h200);
    rd_req = 1'b0;
    tick;
    chk("rd_tmo_pulse", 32'({rd_done, rd_err}), 32'd0);

    // Simultaneous requests over 4 back-to-back bursts
    ctl_auto = 1'b1;
    wr_addr = 28'h0000300;
    rd_addr = 28'h0000400;
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int b = 0; b < 4; b++) begin
      tick;
      w = 0;
      while (!(wc_req || rc_req) && w < 20) begin
        tick;
        w++;
      end
      chk($sformatf("b2b_gap%0d", b), w, 32'd0);
      chk($sformatf("grant_side%0d", b), 32'(wc_req), 32'(exp_seq[b]));
      w = 0;
      while (!(wr_done || rd_done) && w < 50) begin
        tick;
        w++;
      end
      chk($sformatf("done_tmo%0d", b),  32'(w < 50),  32'd1);
      chk($sformatf("done_side%0d", b), 32'(wr_done), 32'(exp_seq[b]));
      chk($sformatf("done_idle%0d", b), 32'(arb_busy), 32'd0);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    ctl_auto = 1'b0;
    repeat (2) tick;

    // Reset during RD_WAIT abandons the burst; pending read is regranted
    rd_addr = 28'h1234567;
    rd_len  = 4'd5;
    rd_req  = 1'b1;
    tick;
    chk("rst_rd_grant", 32'(rc_req), 32'd1);
    man_rc = 1'b1;
    tick;
    chk("rst_rd_wait", 32'({rc_req, arb_busy}), 32'b01);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_busy", 32'(arb_busy), 32'd0);
    chk("rst_async_addr", 32'(rc_addr),  32'd0);
    chk("rst_async_len",  32'(rc_len),   32'd0);
    chk("rst_async_req",  32'({wc_req, rc_req}), 32'd0);
    man_rc = 1'b0;
    tick;
    chk("rst_no_done", 32'({rd_done, rd_err}), 32'd0);
    rstn = 1'b1;
    tick;
    chk("rst_regrant",      32'(rc_req),  32'd1);
    chk("rst_regrant_addr", 32'(rc_addr), 32'h1234567);
    man_rc = 1'b1;
    tick;
    man_rc = 1'b0;
    tick;
    chk("rst_regrant_done", 32'(rd_done), 32'd1);
    rd_req = 1'b0;
    repeat (2) tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
